reg_file: RTL and testbench

- General-purpose register file for the processor datapath: 32 registers x 32 bits, two combinational read ports, one synchronous write port.
- Sits between instruction decode (register addresses) and the ALU/writeback stage.
- Register 0 is hardwired to zero (MIPS convention).

---
 rtl/cpu_pkg.sv | 19 +
 rtl/reg_file_read_port.sv | 26 ++
 rtl/reg_file.sv | 67 ++++++
 tb/tb_reg_file.sv | 133 +++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared datapath constants and types for the register file.
// REG_FILE_WRITE_BYPASS_EN enables same-cycle write-through forwarding on reads.
package cpu_pkg;

   localparam int DATA_W_DEFAULT = 32;
   localparam int ADDR_W_DEFAULT = 5;

   typedef logic [4:0]  reg_addr_t;
   typedef logic [31:0] reg_data_t;

   localparam reg_addr_t ZERO_REG = 5'd0;

`ifdef REG_FILE_WRITE_BYPASS_EN
   localparam bit WRITE_BYPASS_EN = 1'b1;
`else
   localparam bit WRITE_BYPASS_EN = 1'b0;
`endif

endpackage

// File: rtl/reg_file_read_port.sv
// One combinational read port: register select mux plus optional write forwarding.
// Forwarding is active only when REG_FILE_WRITE_BYPASS_EN is defined (via cpu_pkg).
module reg_file_read_port
   import cpu_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEFAULT,
   parameter int ADDR_W = ADDR_W_DEFAULT
) (
   input  logic [DATA_W-1:0] regs [2**ADDR_W],
   input  logic [ADDR_W-1:0] read_addr,
   input  logic              write_en,
   input  logic [ADDR_W-1:0] write_addr,
   input  logic [DATA_W-1:0] write_data,
   output logic [DATA_W-1:0] read_data
);

   logic bypass_hit;

   // Register 0 is never forwarded so it keeps reading as zero.
   always_comb begin
      bypass_hit = WRITE_BYPASS_EN && write_en && (write_addr == read_addr)
                   && (write_addr != ADDR_W'(ZERO_REG));
      read_data  = bypass_hit ? write_data : regs[read_addr];
   end

endmodule

// File: rtl/reg_file.sv
// 2**ADDR_W x DATA_W register file: two combinational read ports, one synchronous write port, r0 hardwired to zero.
// Define REG_FILE_WRITE_BYPASS_EN to forward write data to matching reads in the same cycle.
module reg_file
   import cpu_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEFAULT,
   parameter int ADDR_W = ADDR_W_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] readAddress0,
   input  logic [ADDR_W-1:0] readAddress1,
   input  logic [ADDR_W-1:0] writeAddress,
   input  logic [DATA_W-1:0] writeData,
   input  logic              writeEnable,
   output logic [DATA_W-1:0] readData0,
   output logic [DATA_W-1:0] readData1
);

   localparam int NUM_REGS = 2**ADDR_W;

   logic [DATA_W-1:0] regs_q [NUM_REGS];
   logic [DATA_W-1:0] regs_d [NUM_REGS];

   // Writes to r0 are dropped, so r0 stays at its reset value of zero.
   always_comb begin
      regs_d = regs_q;
      if (writeEnable && (writeAddress != ADDR_W'(ZERO_REG))) begin
         regs_d[writeAddress] = writeData;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   reg_file_read_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_read_port0 (
      .regs       (regs_q),
      .read_addr  (readAddress0),
      .write_en   (writeEnable),
      .write_addr (writeAddress),
      .write_data (writeData),
      .read_data  (readData0)
   );

   reg_file_read_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_read_port1 (
      .regs       (regs_q),
      .read_addr  (readAddress1),
      .write_en   (writeEnable),
      .write_addr (writeAddress),
      .write_data (writeData),
      .read_data  (readData1)
   );

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: a reference array predicts reads, expected values queue up and are popped on compare.
// Pre-edge read-during-write expectation follows REG_FILE_WRITE_BYPASS_EN.
module tb_reg_file;
   import cpu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  readAddress0;
   logic [4:0]  readAddress1;
   logic [4:0]  writeAddress;
   logic [31:0] writeData;
   logic        writeEnable;
   logic [31:0] readData0;
   logic [31:0] readData1;

   reg_data_t   model [32];
   reg_data_t   expQ [$];
   int          assertCount = 0;
   int          failCount = 0;

   always #5 clk = ~clk;

   reg_file dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .readAddress0 (readAddress0),
      .readAddress1 (readAddress1),
      .writeAddress (writeAddress),
      .writeData    (writeData),
      .writeEnable  (writeEnable),
      .readData0    (readData0),
      .readData1    (readData1)
   );

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
      end
   endtask

   // One write cycle: drive on the falling edge, let the rising edge commit, then update the model.
   task automatic applyStimulus(input logic we, input reg_addr_t wa, input reg_data_t wd);
      @(negedge clk);
      writeEnable  = we;
      writeAddress = wa;
      writeData    = wd;
      @(posedge clk);
      #1;
      if (we && (wa != ZERO_REG) && rst_n) model[wa] = wd;
      writeEnable = 1'b0;
   endtask

   task automatic readPorts(input reg_addr_t a0, input reg_addr_t a1, input string tag);
      readAddress0 = a0;
      readAddress1 = a1;
      expQ.push_back(model[a0]);
      expQ.push_back(model[a1]);
      #1;
      checkOutput({tag, "_p0"}, readData0, expQ.pop_front());
      checkOutput({tag, "_p1"}, readData1, expQ.pop_front());
   endtask

   initial begin
      for (int i = 0; i < 32; i++) model[i] = '0;
      rst_n        = 1'b0;
      readAddress0 = 5'd5;
      readAddress1 = 5'd0;
      writeAddress = '0;
      writeData    = '0;
      writeEnable  = 1'b0;

      readPorts(5'd5, 5'd31, "reset_state");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      applyStimulus(1'b1, 5'd16, 32'h0000_0001);
      applyStimulus(1'b1, 5'd17, 32'h0000_0003);
      readPorts(5'd16, 5'd17, "basic_rw");

      applyStimulus(1'b0, 5'd16, 32'h0000_0004);
      applyStimulus(1'b0, 5'd17, 32'h0000_0005);
      applyStimulus(1'b0, 5'd16, 32'hFFFF_FFFF);
      readPorts(5'd16, 5'd17, "we_low");

      applyStimulus(1'b1, 5'd0, 32'hDEAD_BEEF);
      readPorts(5'd0, 5'd0, "zero_reg");

      // Read-during-write on r17 from both ports.
      @(negedge clk);
      readAddress0 = 5'd17;
      readAddress1 = 5'd17;
      writeEnable  = 1'b1;
      writeAddress = 5'd17;
      writeData    = 32'hA5A5_A5A5;
`ifdef REG_FILE_WRITE_BYPASS_EN
      expQ.push_back(32'hA5A5_A5A5);
      expQ.push_back(32'hA5A5_A5A5);
`else
      expQ.push_back(model[17]);
      expQ.push_back(model[17]);
`endif
      #1;
      checkOutput("rdw_pre_p0", readData0, expQ.pop_front());
      checkOutput("rdw_pre_p1", readData1, expQ.pop_front());
      @(posedge clk);
      #1;
      model[17]   = 32'hA5A5_A5A5;
      writeEnable = 1'b0;
      readPorts(5'd17, 5'd17, "rdw_post");

      for (int i = 1; i < 32; i++) applyStimulus(1'b1, reg_addr_t'(i), 32'(i) * 32'h0101_0101);
      for (int i = 0; i < 32; i++) readPorts(reg_addr_t'(i), reg_addr_t'(31 - i), $sformatf("sweep_%0d", i));

      // Asynchronous reset mid-cycle, away from any clock edge.
      applyStimulus(1'b1, 5'd16, 32'h0000_0001);
      #2;
      rst_n = 1'b0;
      for (int i = 0; i < 32; i++) model[i] = '0;
      readPorts(5'd16, 5'd16, "async_reset");
      applyStimulus(1'b1, 5'd16, 32'h0000_0007);
      readPorts(5'd16, 5'd31, "write_in_reset");
      @(negedge clk);
      rst_n = 1'b1;
      readPorts(5'd16, 5'd1, "post_reset");

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
